// File: rtl/mlp_pkg.sv
// Shared constants and helpers for multi_lane_pipe and its round-robin arbiter.
// The optional stall counters are enabled with MLP_STALL_CNT_EN.
package mlp_pkg;

  localparam int STALL_CNT_W = 16;

  // Index width for a lane count, never narrower than one bit.
  function automatic int lane_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the lane after the last granted one.
// The pointer moves only on a cycle that issues a grant.
module rr_arbiter
  import mlp_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int IW = lane_idx_w(N);

  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  req_hi, pick;

  // NOTE: every combinational output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < N; i++) begin
      req_hi[i] = req[i] && (i > int'(last_q));
    end
    pick   = (req_hi != '0) ? req_hi : req;
    grant  = '0;
    last_d = last_q;
    // Descending scan: the lowest set bit of pick wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        last_d   = IW'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) last_q <= IW'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/multi_lane_pipe.sv
// N-lane two-stage stall/flush pipeline sharing one incrementer through a round-robin grant.
// Define MLP_STALL_CNT_EN to add per-lane saturating out_stall cycle counters (stall_cnt).
module multi_lane_pipe
  import mlp_pkg::*;
#(
  parameter int              NUM_LANES = 2,
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] INC     = DATA_W'(1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_LANES*DATA_W-1:0]   pipeline_inputs,
  input  logic [NUM_LANES-1:0]          in_valid,
  input  logic [NUM_LANES-1:0]          flush,
  input  logic [NUM_LANES-1:0]          in_stall,
  output logic [NUM_LANES*DATA_W-1:0]   pipeline_outputs,
  output logic [NUM_LANES-1:0]          out_valid,
  output logic [NUM_LANES-1:0]          out_stall,
  output logic [NUM_LANES-1:0]          grant
`ifdef MLP_STALL_CNT_EN
  ,
  output logic [NUM_LANES*STALL_CNT_W-1:0] stall_cnt
`endif
);

  typedef struct packed {
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
  } lane_state_t;

  lane_state_t [NUM_LANES-1:0] lane_q, lane_d;
  logic [NUM_LANES-1:0]        req;
  logic [DATA_W-1:0]           sel_data, result;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      req[i] = lane_q[i].a_valid && !flush[i] && (!lane_q[i].b_valid || !in_stall[i]);
      out_stall[i] = !flush[i] && lane_q[i].a_valid && !grant[i];
    end
  end

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  // Grant is one-hot or zero, so an OR-mux selects the granted lane's A data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) sel_data = sel_data | lane_q[i].a_data;
    end
    result = sel_data + INC;
  end

  always_comb begin
    lane_d = lane_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (flush[i]) begin
        lane_d[i].a_valid = 1'b0;
        lane_d[i].b_valid = 1'b0;
      end else begin
        if (in_valid[i] && !out_stall[i]) begin
          lane_d[i].a_data  = pipeline_inputs[i*DATA_W +: DATA_W];
          lane_d[i].a_valid = 1'b1;
        end else if (grant[i]) begin
          lane_d[i].a_valid = 1'b0;
        end
        // A granted lane refills B in the same cycle its old B is consumed.
        if (grant[i]) begin
          lane_d[i].b_data  = result;
          lane_d[i].b_valid = 1'b1;
        end else if (lane_q[i].b_valid && !in_stall[i]) begin
          lane_d[i].b_valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lane_q <= '0;
    else       lane_q <= lane_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      pipeline_outputs[i*DATA_W +: DATA_W] = lane_q[i].b_data;
      out_valid[i] = lane_q[i].b_valid;
    end
  end

`ifdef MLP_STALL_CNT_EN
  logic [NUM_LANES-1:0][STALL_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (reset || flush[i])                   cnt_q[i] <= '0;
      else if (out_stall[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_multi_lane_pipe.sv
// Directed self-checking bench for multi_lane_pipe (two lanes, 32-bit, INC = 1).
// Build with MLP_STALL_CNT_EN defined to also exercise the stall counters.
module tb_multi_lane_pipe;

  localparam int NL = 2;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NL*DW-1:0] pipeline_inputs;
  logic [NL-1:0]    in_valid, flush, in_stall;
  logic [NL*DW-1:0] pipeline_outputs;
  logic [NL-1:0]    out_valid, out_stall, grant;
`ifdef MLP_STALL_CNT_EN
  logic [NL*16-1:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  multi_lane_pipe #(.NUM_LANES(NL), .DATA_W(DW), .INC(32'd1)) dut (
    .clk              (clk),
    .reset            (reset),
    .pipeline_inputs  (pipeline_inputs),
    .in_valid         (in_valid),
    .flush            (flush),
    .in_stall         (in_stall),
    .pipeline_outputs (pipeline_outputs),
    .out_valid        (out_valid),
    .out_stall        (out_stall),
    .grant            (grant)
`ifdef MLP_STALL_CNT_EN
    ,
    .stall_cnt        (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipeline_inputs = '0;
    in_valid        = '0;
    flush           = '0;
    in_stall        = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (out_valid !== 2'b00) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid);
    end
    checks++;
    if (pipeline_outputs !== 64'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", pipeline_outputs);
    end
    checks++;
    if (grant !== 2'b00 || out_stall !== 2'b00) begin
      failures++; $display("FAIL reset_grant_stall grant=%b stall=%b exp=00/00", grant, out_stall);
    end
  endtask

  task automatic test_single_lane();
    do_reset();
    in_valid        = 2'b01;
    pipeline_inputs = {32'h0, 32'h10};
    #1;
    checks++;
    if (out_stall !== 2'b00) begin
      failures++; $display("FAIL single_stall0 got=%b exp=00", out_stall);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (grant !== 2'b01 || out_stall !== 2'b00 || out_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_grant grant=%b stall=%b valid=%b exp=01/00/00", grant, out_stall, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 2'b01 || pipeline_outputs[31:0] !== 32'h11) begin
      failures++;
      $display("FAIL single_out valid=%b data=%h exp=01/00000011", out_valid, pipeline_outputs[31:0]);
    end
    step();
    checks++;
    if (out_valid !== 2'b00) begin
      failures++; $display("FAIL single_drain valid=%b exp=00", out_valid);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  g_tab [0:10];
    logic [1:0]  s_tab [0:10];
    logic [31:0] d0, d1, exp_v;
    int          n0, n1;
    g_tab = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    s_tab = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    n0 = 0;
    n1 = 0;
    q0.delete();
    q1.delete();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      d0 = 32'h100 + 32'(n0);
      d1 = 32'h200 + 32'(n1);
      in_valid        = (c < 8) ? 2'b11 : 2'b00;
      pipeline_inputs = {d1, d0};
      #1;
      checks++;
      if (grant !== g_tab[c]) begin
        failures++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, grant, g_tab[c]);
      end
      checks++;
      if (out_stall !== s_tab[c]) begin
        failures++; $display("FAIL contention_stall c=%0d got=%b exp=%b", c, out_stall, s_tab[c]);
      end
      if (c < 8) begin
        if (!s_tab[c][0]) begin q0.push_back(d0); n0++; end
        if (!s_tab[c][1]) begin q1.push_back(d1); n1++; end
      end
      step();
      if (g_tab[c][0]) begin
        checks++;
        if (q0.size() == 0) begin
          failures++; $display("FAIL contention_lane0_extra c=%0d got=%h exp=none", c, pipeline_outputs[31:0]);
        end else begin
          exp_v = q0.pop_front() + 32'd1;
          if (out_valid[0] !== 1'b1 || pipeline_outputs[31:0] !== exp_v) begin
            failures++;
            $display("FAIL contention_lane0 c=%0d got=%h valid=%b exp=%h", c, pipeline_outputs[31:0], out_valid[0], exp_v);
          end
        end
      end
      if (g_tab[c][1]) begin
        checks++;
        if (q1.size() == 0) begin
          failures++; $display("FAIL contention_lane1_extra c=%0d got=%h exp=none", c, pipeline_outputs[63:32]);
        end else begin
          exp_v = q1.pop_front() + 32'd1;
          if (out_valid[1] !== 1'b1 || pipeline_outputs[63:32] !== exp_v) begin
            failures++;
            $display("FAIL contention_lane1 c=%0d got=%h valid=%b exp=%h", c, pipeline_outputs[63:32], out_valid[1], exp_v);
          end
        end
      end
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || n0 != 5 || n1 != 4) begin
      failures++;
      $display("FAIL contention_loss left0=%0d left1=%0d sent0=%0d sent1=%0d exp=0/0/5/4", q0.size(), q1.size(), n0, n1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid        = 2'b10;
    pipeline_inputs = {32'hA0, 32'h0};
    step();
    pipeline_inputs = {32'hA1, 32'h0};
    step();
    in_stall = 2'b10;
    for (int c = 0; c < 5; c++) begin
      in_valid        = 2'b11;
      pipeline_inputs = {32'hA2, 32'h50 + 32'(c)};
      #1;
      checks++;
      if (out_stall[1] !== 1'b1 || grant !== ((c == 0) ? 2'b00 : 2'b01)) begin
        failures++;
        $display("FAIL bp_stall c=%0d stall=%b grant=%b exp_stall1=1 exp_grant=%b", c, out_stall, grant, (c == 0) ? 2'b00 : 2'b01);
      end
      step();
      checks++;
      if (out_valid[1] !== 1'b1 || pipeline_outputs[63:32] !== 32'hA1) begin
        failures++;
        $display("FAIL bp_hold c=%0d valid=%b data=%h exp=1/000000a1", c, out_valid[1], pipeline_outputs[63:32]);
      end
      if (c >= 1) begin
        checks++;
        if (out_valid[0] !== 1'b1 || pipeline_outputs[31:0] !== 32'h50 + 32'(c)) begin
          failures++;
          $display("FAIL bp_lane0 c=%0d valid=%b data=%h exp=%h", c, out_valid[0], pipeline_outputs[31:0], 32'h50 + 32'(c));
        end
      end
    end
    in_stall = 2'b00;
    in_valid = 2'b00;
    #1;
    checks++;
    if (grant !== 2'b10) begin
      failures++; $display("FAIL bp_release_grant got=%b exp=10", grant);
    end
    step();
    checks++;
    if (out_valid[1] !== 1'b1 || pipeline_outputs[63:32] !== 32'hA2) begin
      failures++;
      $display("FAIL bp_release_lane1 valid=%b data=%h exp=1/000000a2", out_valid[1], pipeline_outputs[63:32]);
    end
    step();
    checks++;
    if (out_valid[0] !== 1'b1 || pipeline_outputs[31:0] !== 32'h55) begin
      failures++;
      $display("FAIL bp_release_lane0 valid=%b data=%h exp=1/00000055", out_valid[0], pipeline_outputs[31:0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid        = 2'b11;
    pipeline_inputs = {32'h70, 32'h30};
    step();
    in_valid        = 2'b01;
    pipeline_inputs = {32'h0, 32'h31};
    #1;
    checks++;
    if (grant !== 2'b01 || out_stall !== 2'b10) begin
      failures++; $display("FAIL flush_setup grant=%b stall=%b exp=01/10", grant, out_stall);
    end
    step();
    checks++;
    if (out_valid[0] !== 1'b1 || pipeline_outputs[31:0] !== 32'h31) begin
      failures++;
      $display("FAIL flush_full valid=%b data=%h exp=1/00000031", out_valid[0], pipeline_outputs[31:0]);
    end
    flush           = 2'b01;
    in_valid        = 2'b01;
    in_stall        = 2'b01;
    pipeline_inputs = {32'h0, 32'h32};
    #1;
    checks++;
    if (grant !== 2'b10 || out_stall !== 2'b00) begin
      failures++; $display("FAIL flush_grant grant=%b stall=%b exp=10/00", grant, out_stall);
    end
    step();
    checks++;
    if (out_valid !== 2'b10 || pipeline_outputs[63:32] !== 32'h71) begin
      failures++;
      $display("FAIL flush_result valid=%b data1=%h exp=10/00000071", out_valid, pipeline_outputs[63:32]);
    end
    idle_inputs();
    #1;
    checks++;
    if (grant !== 2'b00) begin
      failures++; $display("FAIL flush_dropped_grant got=%b exp=00", grant);
    end
    step();
    checks++;
    if (out_valid !== 2'b00) begin
      failures++; $display("FAIL flush_dropped_out got=%b exp=00", out_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid        = 2'b01;
    pipeline_inputs = {32'h0, 32'hFFFF_FFFF};
    step();
    idle_inputs();
    step();
    checks++;
    if (out_valid[0] !== 1'b1 || pipeline_outputs[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL wrap valid=%b data=%h exp=1/00000000", out_valid[0], pipeline_outputs[31:0]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid        = 2'b11;
    pipeline_inputs = {32'h900, 32'h800};
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (out_valid !== 2'b00 || pipeline_outputs !== 64'd0 || grant !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset valid=%b data=%h grant=%b exp=00/0/00", out_valid, pipeline_outputs, grant);
    end
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if (out_valid !== 2'b00) begin
      failures++; $display("FAIL mid_reset_discard got=%b exp=00", out_valid);
    end
  endtask

`ifdef MLP_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    in_valid        = 2'b10;
    pipeline_inputs = {32'h1, 32'h0};
    step();
    pipeline_inputs = {32'h2, 32'h0};
    step();
    in_valid = 2'b00;
    in_stall = 2'b10;
    step();
    step();
    step();
    checks++;
    if (stall_cnt[31:16] !== 16'd3 || stall_cnt[15:0] !== 16'd0) begin
      failures++;
      $display("FAIL stall_cnt lane1=%0d lane0=%0d exp=3/0", stall_cnt[31:16], stall_cnt[15:0]);
    end
    flush = 2'b10;
    step();
    flush = 2'b00;
    checks++;
    if (stall_cnt[31:16] !== 16'd0) begin
      failures++; $display("FAIL stall_cnt_flush lane1=%0d exp=0", stall_cnt[31:16]);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_lane();
    test_contention();
    test_backpressure();
    test_flush();
    test_wrap();
    test_mid_reset();
`ifdef MLP_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
